// File: rtl/chirp_burst_gen.sv
// rtl/chirp_burst_gen.sv - burst chirp square-wave generator with free-running DA clock and sample codes
// Optional feature macro: CHIRP_TRIANGLE_EN (triangle half-period sweep inside each burst)
module chirp_burst_gen #(
  parameter int                DATA_W        = 14,
  parameter int                CNT_W         = 16,
  parameter int                DIV_START     = 5400,
  parameter int                DIV_STOP      = 54,
  parameter int                DIV_STEP      = 1,
  parameter int                BURST_HALFCYC = 1000,
  parameter int                GAP_CYC       = 65535,
  parameter int                DA_HALF_DIV   = 3,
  parameter logic [DATA_W-1:0] HI_CODE       = 14'h3FFF,
  parameter logic [DATA_W-1:0] LO_CODE       = 14'h0000,
  parameter logic [DATA_W-1:0] MID_CODE      = 14'h2000
) (
  input  logic              Sys_Clock,
  input  logic              nReset,
  input  logic              run,
  output logic              sq_out,
  output logic              burst_active,
  output logic              burst_done,
  output logic [CNT_W-1:0]  cur_div,
  output logic              DA_Clock,
  output logic [DATA_W-1:0] DA_Data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [CNT_W-1:0] START_C     = CNT_W'(DIV_START);
  localparam logic [CNT_W-1:0] STOP_C      = CNT_W'(DIV_STOP);
  localparam logic [CNT_W-1:0] STEP_C      = CNT_W'(DIV_STEP);
  localparam logic [CNT_W-1:0] LAST_HALF_C = CNT_W'(BURST_HALFCYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST_C  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] DA_LAST_C   = CNT_W'(DA_HALF_DIV - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] half_cnt;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] da_cnt;
  logic [CNT_W-1:0] div_dn;
  logic [CNT_W-1:0] div_next;
  logic             toggle;
  logic             last_toggle;
  logic             gap_done;
  logic             burst_start;
  logic             da_fall;

  assign burst_active = (state == S_BURST);
  assign toggle       = (state == S_BURST) && (half_cnt == {{(CNT_W-1){1'b0}}, 1'b1});
  assign last_toggle  = toggle && (burst_cnt == LAST_HALF_C);
  assign gap_done     = (state == S_GAP) && run && (gap_cnt == GAP_LAST_C);
  assign burst_start  = ((state == S_IDLE) && run) || gap_done;

  // Downward step saturating at DIV_STOP; compared in CNT_W+1 bits so a large step cannot wrap
  always_comb begin
    div_dn = STOP_C;
    if ({1'b0, cur_div} >= ({1'b0, STOP_C} + {1'b0, STEP_C})) begin
      div_dn = cur_div - STEP_C;
    end
  end

`ifdef CHIRP_TRIANGLE_EN
  logic             sweep_up;
  logic [CNT_W-1:0] div_up;

  // Upward step saturating at DIV_START
  always_comb begin
    div_up = START_C;
    if (({1'b0, cur_div} + {1'b0, STEP_C}) <= {1'b0, START_C}) begin
      div_up = cur_div + STEP_C;
    end
  end

  assign div_next = sweep_up ? div_up : div_dn;

  // Sweep direction: starts downward each burst, flips when either end of the range is reached
  always_ff @(posedge Sys_Clock or negedge nReset) begin
    if (!nReset) begin
      sweep_up <= 1'b0;
    end else if (burst_start) begin
      sweep_up <= 1'b0;
    end else if (toggle) begin
      if (!sweep_up && (div_dn == STOP_C)) begin
        sweep_up <= 1'b1;
      end else if (sweep_up && (div_up == START_C)) begin
        sweep_up <= 1'b0;
      end
    end
  end
`else
  assign div_next = div_dn;
`endif

  // Burst FSM: half-period counting, sweep update, burst/gap sequencing
  always_ff @(posedge Sys_Clock or negedge nReset) begin
    if (!nReset) begin
      state      <= S_IDLE;
      sq_out     <= 1'b0;
      burst_done <= 1'b0;
      cur_div    <= START_C;
      half_cnt   <= '0;
      burst_cnt  <= '0;
      gap_cnt    <= '0;
    end else begin
      burst_done <= 1'b0;
      if (burst_start) begin
        state     <= S_BURST;
        sq_out    <= 1'b1;
        cur_div   <= START_C;
        half_cnt  <= START_C;
        burst_cnt <= '0;
      end else begin
        case (state)
          S_BURST: begin
            if (toggle) begin
              burst_cnt <= burst_cnt + 1'b1;
              cur_div   <= div_next;
              half_cnt  <= div_next;
              if (last_toggle) begin
                // Final half ends low; run is only consulted here so a burst is never cut short
                burst_done <= 1'b1;
                sq_out     <= 1'b0;
                gap_cnt    <= '0;
                state      <= run ? S_GAP : S_IDLE;
              end else begin
                sq_out <= ~sq_out;
              end
            end else begin
              half_cnt <= half_cnt - 1'b1;
            end
          end
          S_GAP: begin
            if (!run) begin
              state <= S_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign da_fall = (da_cnt == DA_LAST_C) && DA_Clock;

  // Free-running DA clock divider, toggles every DA_HALF_DIV system clocks
  always_ff @(posedge Sys_Clock or negedge nReset) begin
    if (!nReset) begin
      da_cnt   <= '0;
      DA_Clock <= 1'b1;
    end else if (da_cnt == DA_LAST_C) begin
      da_cnt   <= '0;
      DA_Clock <= ~DA_Clock;
    end else begin
      da_cnt <= da_cnt + 1'b1;
    end
  end

  // DA sample register, updated on the DA falling edge so it is settled at the next rising edge
  always_ff @(posedge Sys_Clock or negedge nReset) begin
    if (!nReset) begin
      DA_Data <= MID_CODE;
    end else if (da_fall) begin
      if (state == S_BURST) begin
        DA_Data <= sq_out ? HI_CODE : LO_CODE;
      end else begin
        DA_Data <= MID_CODE;
      end
    end
  end

endmodule

// File: tb/tb_chirp_burst_gen.sv
// tb/tb_chirp_burst_gen.sv - directed self-checking bench for chirp_burst_gen
module tb_chirp_burst_gen;

  localparam int DW = 14;
  localparam int CW = 16;
  localparam logic [DW-1:0] HI  = 14'h3FFF;
  localparam logic [DW-1:0] LO  = 14'h0000;
  localparam logic [DW-1:0] MID = 14'h2000;

  logic          Sys_Clock = 1'b0;
  logic          nReset    = 1'b0;
  logic          run       = 1'b0;
  logic          run5      = 1'b0;
  logic          sq_out, burst_active, burst_done, DA_Clock;
  logic [CW-1:0] cur_div;
  logic [DW-1:0] DA_Data;
  logic          sq_out5, burst_active5, burst_done5, DA_Clock5;
  logic [CW-1:0] cur_div5;
  logic [DW-1:0] DA_Data5;

  int compared   = 0;
  int mismatched = 0;
  int exp_a [6];
  int exp_b [6];

  always #5 Sys_Clock = ~Sys_Clock;

  chirp_burst_gen #(
    .DATA_W(DW), .CNT_W(CW), .DIV_START(8), .DIV_STOP(4), .DIV_STEP(2),
    .BURST_HALFCYC(6), .GAP_CYC(10), .DA_HALF_DIV(3),
    .HI_CODE(HI), .LO_CODE(LO), .MID_CODE(MID)
  ) u_dut (
    .Sys_Clock(Sys_Clock), .nReset(nReset), .run(run),
    .sq_out(sq_out), .burst_active(burst_active), .burst_done(burst_done),
    .cur_div(cur_div), .DA_Clock(DA_Clock), .DA_Data(DA_Data)
  );

  chirp_burst_gen #(
    .DATA_W(DW), .CNT_W(CW), .DIV_START(8), .DIV_STOP(4), .DIV_STEP(5),
    .BURST_HALFCYC(6), .GAP_CYC(10), .DA_HALF_DIV(3),
    .HI_CODE(HI), .LO_CODE(LO), .MID_CODE(MID)
  ) u_dut5 (
    .Sys_Clock(Sys_Clock), .nReset(nReset), .run(run5),
    .sq_out(sq_out5), .burst_active(burst_active5), .burst_done(burst_done5),
    .cur_div(cur_div5), .DA_Clock(DA_Clock5), .DA_Data(DA_Data5)
  );

  function automatic logic f_sq(input bit s5);
    return s5 ? sq_out5 : sq_out;
  endfunction
  function automatic logic f_ba(input bit s5);
    return s5 ? burst_active5 : burst_active;
  endfunction
  function automatic logic f_done(input bit s5);
    return s5 ? burst_done5 : burst_done;
  endfunction
  function automatic logic [CW-1:0] f_div(input bit s5);
    return s5 ? cur_div5 : cur_div;
  endfunction
  function automatic int f_exp(input bit s5, input int i);
    return s5 ? exp_b[i] : exp_a[i];
  endfunction

  // Called on the sample where sq_out has just risen; measures all six half-periods of one burst
  task automatic measure_burst(input bit s5, input string tag);
    int   n;
    int   pulses;
    logic v;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      v = f_sq(s5);
      n = 0;
      while (f_sq(s5) === v && n < 200) begin
        @(negedge Sys_Clock);
        n++;
        if (f_done(s5) === 1'b1) pulses++;
      end
      compared++;
      if (n !== f_exp(s5, i)) begin
        mismatched++;
        $display("FAIL %s half%0d: got %0d clks, want %0d", tag, i, n, f_exp(s5, i));
      end
      compared++;
      if (f_div(s5) !== CW'(f_exp(s5, i + 1))) begin
        mismatched++;
        $display("FAIL %s cur_div after half%0d: got %0d, want %0d", tag, i, f_div(s5), f_exp(s5, i + 1));
      end
    end
    n = 0;
    while (f_done(s5) !== 1'b1 && n < 200) begin
      @(negedge Sys_Clock);
      n++;
    end
    compared++;
    if (n !== f_exp(s5, 5)) begin
      mismatched++;
      $display("FAIL %s half5 (to burst_done): got %0d clks, want %0d", tag, n, f_exp(s5, 5));
    end
    compared++;
    if ({f_sq(s5), f_ba(s5)} !== 2'b00) begin
      mismatched++;
      $display("FAIL %s end state {sq,active}: got %b, want 00", tag, {f_sq(s5), f_ba(s5)});
    end
    compared++;
    if (pulses !== 0) begin
      mismatched++;
      $display("FAIL %s early burst_done pulses: got %0d, want 0", tag, pulses);
    end
  endtask

  task automatic test_reset;
    nReset = 1'b0;
    run    = 1'b0;
    run5   = 1'b0;
    #12;
    compared++;
    if ({sq_out, burst_active, burst_done, DA_Clock, cur_div, DA_Data} !== {1'b0, 1'b0, 1'b0, 1'b1, 16'd8, MID}) begin
      mismatched++;
      $display("FAIL reset dut: got %h, want %h", {sq_out, burst_active, burst_done, DA_Clock, cur_div, DA_Data},
               {1'b0, 1'b0, 1'b0, 1'b1, 16'd8, MID});
    end
    compared++;
    if ({sq_out5, burst_active5, burst_done5, DA_Clock5, cur_div5, DA_Data5} !== {1'b0, 1'b0, 1'b0, 1'b1, 16'd8, MID}) begin
      mismatched++;
      $display("FAIL reset dut5: got %h, want %h", {sq_out5, burst_active5, burst_done5, DA_Clock5, cur_div5, DA_Data5},
               {1'b0, 1'b0, 1'b0, 1'b1, 16'd8, MID});
    end
    @(negedge Sys_Clock);
    nReset = 1'b1;
  endtask

  task automatic test_da_clock;
    logic e;
    for (int k = 1; k <= 9; k++) begin
      @(negedge Sys_Clock);
      e = ((k / 3) % 2 == 0);
      compared++;
      if (DA_Clock !== e) begin
        mismatched++;
        $display("FAIL da_clock clk%0d: got %b, want %b", k, DA_Clock, e);
      end
    end
    compared++;
    if (DA_Data !== MID) begin
      mismatched++;
      $display("FAIL da_idle_data: got %h, want %h", DA_Data, MID);
    end
  endtask

  task automatic test_burst;
    int n;
    int pulses;
    run = 1'b1;
    n = 0;
    while (sq_out !== 1'b1 && n < 50) begin
      @(negedge Sys_Clock);
      n++;
    end
    compared++;
    if (n !== 1) begin
      mismatched++;
      $display("FAIL burst start latency: got %0d, want 1", n);
    end
    compared++;
    if ({burst_active, cur_div} !== {1'b1, 16'd8}) begin
      mismatched++;
      $display("FAIL burst entry {active,cur_div}: got %h, want %h", {burst_active, cur_div}, {1'b1, 16'd8});
    end
    measure_burst(1'b0, "burst1");
    n = 0;
    pulses = 0;
    while (sq_out === 1'b0 && n < 200) begin
      @(negedge Sys_Clock);
      n++;
      if (burst_done === 1'b1) pulses++;
    end
    compared++;
    if (n !== 10) begin
      mismatched++;
      $display("FAIL gap length: got %0d clks, want 10", n);
    end
    compared++;
    if (pulses !== 0) begin
      mismatched++;
      $display("FAIL burst_done width: got %0d extra pulses, want 0", pulses);
    end
    compared++;
    if ({burst_active, cur_div} !== {1'b1, 16'd8}) begin
      mismatched++;
      $display("FAIL burst2 entry {active,cur_div}: got %h, want %h", {burst_active, cur_div}, {1'b1, 16'd8});
    end
  endtask

  // Entered on the first sample of a burst; run drops 12 clocks in
  task automatic test_run_drop;
    int n;
    int total;
    int bad;
    total = 0;
    for (int i = 0; i < 6; i++) total += exp_a[i];
    n = 0;
    repeat (12) begin
      @(negedge Sys_Clock);
      n++;
    end
    run = 1'b0;
    while (burst_active === 1'b1 && n < 200) begin
      @(negedge Sys_Clock);
      n++;
    end
    compared++;
    if (n !== total) begin
      mismatched++;
      $display("FAIL run_drop burst length: got %0d clks, want %0d", n, total);
    end
    compared++;
    if (burst_done !== 1'b1) begin
      mismatched++;
      $display("FAIL run_drop burst_done: got %b, want 1", burst_done);
    end
    bad = 0;
    repeat (20) begin
      @(negedge Sys_Clock);
      if (sq_out !== 1'b0 || burst_active !== 1'b0) bad++;
    end
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("FAIL run_drop idle: got %0d active cycles, want 0", bad);
    end
    compared++;
    if (DA_Data !== MID) begin
      mismatched++;
      $display("FAIL run_drop DA_Data: got %h, want %h", DA_Data, MID);
    end
  endtask

  task automatic test_da_data;
    logic          p_da, p_sq, p_ba;
    logic [DW-1:0] p_data, e;
    int            since, bad_data, bad_per, n;
    bit            seen_tog, seen_hi, seen_lo, seen_mid;
    p_da = DA_Clock; p_sq = sq_out; p_ba = burst_active; p_data = DA_Data;
    since = 0; bad_data = 0; bad_per = 0;
    seen_tog = 0; seen_hi = 0; seen_lo = 0; seen_mid = 0;
    run = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge Sys_Clock);
      since++;
      if (p_da === 1'b1 && DA_Clock === 1'b0) e = p_ba ? (p_sq ? HI : LO) : MID;
      else e = p_data;
      if (DA_Data !== e) begin
        bad_data++;
        $display("FAIL da_data cycle%0d: got %h, want %h", c, DA_Data, e);
      end
      if (DA_Clock !== p_da) begin
        if (seen_tog && since !== 3) bad_per++;
        seen_tog = 1;
        since = 0;
      end
      if (DA_Data === HI) seen_hi = 1;
      if (DA_Data === LO) seen_lo = 1;
      if (DA_Data === MID) seen_mid = 1;
      p_da = DA_Clock; p_sq = sq_out; p_ba = burst_active; p_data = DA_Data;
    end
    compared++;
    if (bad_data !== 0) begin
      mismatched++;
      $display("FAIL da_data: got %0d bad samples, want 0", bad_data);
    end
    compared++;
    if (bad_per !== 0) begin
      mismatched++;
      $display("FAIL da_period: got %0d bad half-periods, want 0", bad_per);
    end
    compared++;
    if ({seen_hi, seen_lo, seen_mid} !== 3'b111) begin
      mismatched++;
      $display("FAIL da_codes seen {hi,lo,mid}: got %b, want 111", {seen_hi, seen_lo, seen_mid});
    end
    run = 1'b0;
    n = 0;
    while (burst_active === 1'b1 && n < 100) begin
      @(negedge Sys_Clock);
      n++;
    end
    compared++;
    if (burst_active !== 1'b0) begin
      mismatched++;
      $display("FAIL da_data wind-down: burst_active got %b, want 0", burst_active);
    end
    repeat (8) @(negedge Sys_Clock);
  endtask

  task automatic test_step5;
    int n;
    run5 = 1'b1;
    n = 0;
    while (sq_out5 !== 1'b1 && n < 50) begin
      @(negedge Sys_Clock);
      n++;
    end
    compared++;
    if (n !== 1) begin
      mismatched++;
      $display("FAIL step5 start latency: got %0d, want 1", n);
    end
    measure_burst(1'b1, "step5");
    run5 = 1'b0;
    repeat (4) @(negedge Sys_Clock);
    compared++;
    if ({burst_active5, sq_out5} !== 2'b00) begin
      mismatched++;
      $display("FAIL step5 idle {active,sq}: got %b, want 00", {burst_active5, sq_out5});
    end
  endtask

  task automatic test_reset_mid_burst;
    int   n;
    run = 1'b1;
    n = 0;
    while (sq_out !== 1'b1 && n < 50) begin
      @(negedge Sys_Clock);
      n++;
    end
    repeat (5) @(negedge Sys_Clock);
    #2;
    nReset = 1'b0;
    #1;
    compared++;
    if ({sq_out, burst_active, burst_done, DA_Clock, cur_div, DA_Data} !== {1'b0, 1'b0, 1'b0, 1'b1, 16'd8, MID}) begin
      mismatched++;
      $display("FAIL mid_reset outputs: got %h, want %h", {sq_out, burst_active, burst_done, DA_Clock, cur_div, DA_Data},
               {1'b0, 1'b0, 1'b0, 1'b1, 16'd8, MID});
    end
    @(negedge Sys_Clock);
    nReset = 1'b1;
    n = 0;
    while (sq_out !== 1'b1 && n < 50) begin
      @(negedge Sys_Clock);
      n++;
    end
    compared++;
    if (n !== 1) begin
      mismatched++;
      $display("FAIL mid_reset restart latency: got %0d, want 1", n);
    end
    n = 0;
    while (sq_out === 1'b1 && n < 200) begin
      @(negedge Sys_Clock);
      n++;
    end
    compared++;
    if (n !== 8) begin
      mismatched++;
      $display("FAIL mid_reset first high half: got %0d clks, want 8", n);
    end
    run = 1'b0;
    n = 0;
    while (burst_active === 1'b1 && n < 100) begin
      @(negedge Sys_Clock);
      n++;
    end
  endtask

  initial begin
`ifdef CHIRP_TRIANGLE_EN
    exp_a = '{8, 6, 4, 6, 8, 6};
    exp_b = '{8, 4, 8, 4, 8, 4};
`else
    exp_a = '{8, 6, 4, 4, 4, 4};
    exp_b = '{8, 4, 4, 4, 4, 4};
`endif
    test_reset();
    test_da_clock();
    test_burst();
    test_run_drop();
    test_da_data();
    test_step5();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/chirp_burst_gen.md
Name: chirp_burst_gen

Overview:
Parametrised burst chirp generator for the DA test path. It emits a square wave whose half-period sweeps from DIV_START to DIV_STOP system clocks over a burst of BURST_HALFCYC half-cycles, followed by a gap of GAP_CYC clocks, repeating while run is high. It also produces a free-running DA clock and registers DA sample codes (high/low/mid level) aligned to that clock. It sits between the system clock domain (108 MHz) and the external DA converter.

Parameters:
DATA_W, 14, DA data width
CNT_W, 16, width of all divider/burst/gap counters
DIV_START, 5400, first half-period in Sys_Clock cycles (10 kHz at 108 MHz)
DIV_STOP, 54, final half-period (1 MHz); constraint 1 <= DIV_STOP <= DIV_START
DIV_STEP, 1, half-period decrement applied after each toggle
BURST_HALFCYC, 1000, half-cycles per burst; must be even and >= 2
GAP_CYC, 65535, idle clocks between bursts; >= 1
DA_HALF_DIV, 3, DA_Clock half-period in Sys_Clock cycles (18 MHz); >= 1
HI_CODE, 14'h3FFF, DA code while sq_out=1
LO_CODE, 14'h0000, DA code while sq_out=0 in burst
MID_CODE, 14'h2000, DA code in IDLE/GAP and after reset

Ports:
Sys_Clock  input  1  system clock, all logic on rising edge
nReset  input  1  asynchronous, active-low reset
run  input  1  level; high enables burst generation
sq_out  output  1  square-wave output
burst_active  output  1  high while in BURST state
burst_done  output  1  one-cycle pulse on the final toggle of each burst
cur_div  output  CNT_W  half-period currently being counted
DA_Clock  output  1  DA converter clock
DA_Data  output  DATA_W  registered DA sample code

Behaviour:
- Reset (async, nReset low): state=IDLE, sq_out=0, burst_active=0, burst_done=0, cur_div=DIV_START, half counter=0, burst/gap counters=0, DA_Clock=1, DA counter=0, DA_Data=MID_CODE.
- FSM states: IDLE, BURST, GAP.
- IDLE: if run=1 at an edge, go to BURST next cycle; sq_out=1, cur_div=DIV_START, half counter loaded with DIV_START, burst count=0.
- BURST: half counter decrements each clock; when it reads 1: toggle sq_out, burst count+1, cur_div <= max(cur_div-DIV_STEP, DIV_STOP) (saturating, no underflow even if DIV_STEP > cur_div), reload half counter with the new cur_div. The first high half therefore lasts exactly DIV_START clocks.
- On the toggle where burst count reaches BURST_HALFCYC: burst_done=1 for that cycle, sq_out ends at 0. Next state is GAP if run=1, else IDLE. A run deassertion mid-burst never truncates a burst.
- GAP: sq_out=0; count GAP_CYC clocks, then reload cur_div=DIV_START and re-enter BURST as from IDLE. If run=0 at any GAP cycle, go to IDLE immediately.
- burst_active=1 exactly in BURST. cur_div resets to DIV_START on every entry to BURST.
- DA clock: free-running, independent of the FSM; counter counts 1..DA_HALF_DIV, and DA_Clock toggles on the cycle it reaches DA_HALF_DIV, then the counter clears. Period is 2*DA_HALF_DIV clocks.
- DA_Data updates only on the cycle DA_Clock toggles 1->0, so it is stable at the DA rising edge. Value: BURST and sq_out=1 -> HI_CODE; BURST and sq_out=0 -> LO_CODE; IDLE/GAP -> MID_CODE.
- Reset mid-burst: all outputs return to reset values asynchronously. The first burst after release starts only when run is sampled high.

Optional Feature:
CHIRP_TRIANGLE_EN. When it is defined, reaching DIV_STOP reverses the sweep: subsequent toggles add DIV_STEP, saturating at DIV_START, then reverse again (triangle sweep within a burst). Direction resets to downward on each burst entry. When it is not defined, the sweep saturates at DIV_STOP for the rest of the burst.

Test Plan:
- DIV_START=8, DIV_STOP=4, DIV_STEP=2, BURST_HALFCYC=6, GAP_CYC=10; run=1 -> half-periods 8,6,4,4,4,4 (30 clks); burst_done pulses once; sq_out=0 for 10 clks; next burst starts with 8.
- Same parameters with CHIRP_TRIANGLE_EN defined -> half-periods 8,6,4,6,8,6.
- run dropped at clk 12 of a burst -> burst completes all 30 clks, then IDLE with no GAP; DA_Data=MID_CODE afterwards.
- DA_HALF_DIV=3 -> DA_Clock period 6 clks, first toggle to 0 on the 3rd clk after reset; DA_Data changes only on 1->0 toggles and equals HI_CODE/LO_CODE/MID_CODE per state.
- DIV_STEP=5, DIV_START=8, DIV_STOP=4 -> half-periods 8,4,4,...; no underflow or wrap of cur_div.
- nReset asserted mid-burst -> sq_out=0, DA_Clock=1, DA_Data=MID_CODE, cur_div=DIV_START immediately; after release with run=1, the first high half lasts DIV_START clks.
